// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR unit.
// Holds the architected M-mode CSRs and the cycle/instret counters. It also
// sequences trap entry and mret.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   csr_valid         CSR instruction issues this cycle
//   csr_funct3        operation (rw/rs/rc and immediate forms)
//   csr_addr          12-bit CSR address
//   csr_rs1_data      rs1 operand
//   csr_zimm          immediate operand / rs1 index
//   csr_rd_data       old value of the addressed CSR (combinational)
//   csr_illegal       unimplemented address or write to a read-only CSR
//   trap_valid        take a trap (cause/pc/tval supplied alongside)
//   trap_cause, trap_pc, trap_tval
//   mret_valid        mret commits this cycle
//   instret_inc       one instruction retired
//   trap_vector       redirect target for the current trap (combinational)
//   mepc_out          current mepc
//   irq_enable        mstatus.MIE
// XLEN must be 32 or 64.
module csr_file_m #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_rs1_data,
    input  logic [4:0]      csr_zimm,
    output logic [XLEN-1:0] csr_rd_data,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            instret_inc,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_enable
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0]      MXL  = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA = {MXL, {(XLEN-11){1'b0}}, 9'h100};

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [XLEN-1:0] rd_val, src, wval, vec_base;
    logic            impl, ro, wr_req, wr_en;

    // High counter halves exist only on RV32; the spliced values let a write
    // replace one half while the other keeps its current contents.
    logic [XLEN-1:0] cyc_hi, ins_hi;
    logic [63:0]     cyc_wlo, cyc_whi, ins_wlo, ins_whi;

    generate
        if (XLEN == 32) begin : g_rv32
            assign cyc_hi  = mcycle_q[63:32];
            assign ins_hi  = minstret_q[63:32];
            assign cyc_wlo = {mcycle_q[63:32], wval};
            assign cyc_whi = {wval, mcycle_q[31:0]};
            assign ins_wlo = {minstret_q[63:32], wval};
            assign ins_whi = {wval, minstret_q[31:0]};
        end else begin : g_rv64
            assign cyc_hi  = '0;
            assign ins_hi  = '0;
            assign cyc_wlo = wval;
            assign cyc_whi = mcycle_q;
            assign ins_wlo = wval;
            assign ins_whi = minstret_q;
        end
    endgenerate

    // Read decode: also classifies the address as implemented / read-only.
    always_comb begin
        rd_val = '0;
        impl   = 1'b1;
        ro     = 1'b0;
        case (csr_addr)
            A_MSTATUS: begin
                rd_val[12:11] = 2'b11;
                rd_val[7]     = mpie_q;
                rd_val[3]     = mie_q;
            end
            A_MISA:      begin rd_val = MISA;    ro = 1'b1; end
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MTVAL:     rd_val = mtval_q;
            A_MCYCLE:    rd_val = mcycle_q[XLEN-1:0];
            A_MINSTRET:  rd_val = minstret_q[XLEN-1:0];
            A_MCYCLEH:   if (XLEN == 32) rd_val = cyc_hi; else impl = 1'b0;
            A_MINSTRETH: if (XLEN == 32) rd_val = ins_hi; else impl = 1'b0;
            A_MHARTID:   begin rd_val = HART_ID; ro = 1'b1; end
            default:     impl = 1'b0;
        endcase
    end

    assign csr_rd_data = rd_val;

    // Set/clear with a zero operand field never writes; rw forms always do.
    assign src    = csr_funct3[2] ? {{(XLEN-5){1'b0}}, csr_zimm} : csr_rs1_data;
    assign wr_req = csr_valid && ((csr_funct3[1:0] == 2'b01) ||
                    ((csr_funct3[1:0] != 2'b00) && (csr_zimm != 5'd0)));
    assign csr_illegal = csr_valid && (!impl || (ro && wr_req));
    assign wr_en  = wr_req && impl && !ro && !trap_valid && !mret_valid;

    always_comb begin
        case (csr_funct3[1:0])
            2'b01:   wval = src;
            2'b10:   wval = rd_val | src;
            2'b11:   wval = rd_val & ~src;
            default: wval = rd_val;
        endcase
    end

    // Next state: trap beats mret beats a CSR write.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret_inc};
        if (trap_valid) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                // Reserved vector modes 2/3 collapse to direct mode.
                A_MTVEC:     mtvec_d = {wval[XLEN-1:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      mepc_d = {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:    mcause_d = wval;
                A_MTVAL:     mtval_d = wval;
                A_MCYCLE:    mcycle_d = cyc_wlo;
                A_MINSTRET:  minstret_d = ins_wlo;
                A_MCYCLEH:   mcycle_d = cyc_whi;
                A_MINSTRETH: minstret_d = ins_whi;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Vectored mode offsets only interrupts; 4*cause wraps within XLEN.
    assign vec_base    = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1]) ?
                         vec_base + {trap_cause[XLEN-3:0], 2'b00} : vec_base;
    assign mepc_out    = mepc_q;
    assign irq_enable  = mie_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Testbench for csr_file_m: RV32 and RV64 instances share one stimulus stream
// and are compared against a behavioural CSR model.
module tb_csr_file_m;

    logic        clk;
    logic        rst, csr_valid, trap_valid, mret_valid, inc;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [63:0] rs1, cause, pc, tval;
    logic [4:0]  zimm;

    logic [31:0] rd32, tv32, mepc32;
    logic        ill32, irq32;
    logic [63:0] rd64, tv64, mepc64;
    logic        ill64, irq64;

    int total = 0;
    int bad   = 0;

    logic [2:0]  f3s  [6]  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [11:0] adrs [12] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14};

    csr_file_m #(.XLEN(32), .HART_ID(32'd5), .MTVEC_RESET(32'h200)) d32 (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_funct3(f3), .csr_addr(addr),
        .csr_rs1_data(rs1[31:0]), .csr_zimm(zimm), .csr_rd_data(rd32), .csr_illegal(ill32),
        .trap_valid(trap_valid), .trap_cause(cause[31:0]), .trap_pc(pc[31:0]),
        .trap_tval(tval[31:0]), .mret_valid(mret_valid), .instret_inc(inc),
        .trap_vector(tv32), .mepc_out(mepc32), .irq_enable(irq32));

    csr_file_m #(.XLEN(64), .HART_ID(64'd9), .MTVEC_RESET(64'h1_0000_0400)) d64 (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_funct3(f3), .csr_addr(addr),
        .csr_rs1_data(rs1), .csr_zimm(zimm), .csr_rd_data(rd64), .csr_illegal(ill64),
        .trap_valid(trap_valid), .trap_cause(cause), .trap_pc(pc),
        .trap_tval(tval), .mret_valid(mret_valid), .instret_inc(inc),
        .trap_vector(tv64), .mepc_out(mepc64), .irq_enable(irq64));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int          xl;
        logic [63:0] hart, mtvr;
        logic [63:0] mtvec, mscratch, mepc, mcause, mtval, cyc, ins;
        logic        mie, mpie;
    } st_t;

    st_t m32, m64;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk(st_t s);
        return (s.xl == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] m_read(st_t s, logic [11:0] a, output bit impl, output bit ro);
        logic [63:0] r;
        r = 64'd0; impl = 1'b1; ro = 1'b0;
        case (a)
            12'h300: r = 64'h1800 | (64'(s.mpie) << 7) | (64'(s.mie) << 3);
            12'h301: begin r = (s.xl == 32) ? 64'h4000_0100 : 64'h8000_0000_0000_0100; ro = 1'b1; end
            12'h305: r = s.mtvec;
            12'h340: r = s.mscratch;
            12'h341: r = s.mepc;
            12'h342: r = s.mcause;
            12'h343: r = s.mtval;
            12'hB00: r = s.cyc & msk(s);
            12'hB02: r = s.ins & msk(s);
            12'hB80: if (s.xl == 32) r = s.cyc >> 32; else impl = 1'b0;
            12'hB82: if (s.xl == 32) r = s.ins >> 32; else impl = 1'b0;
            12'hF14: begin r = s.hart; ro = 1'b1; end
            default: impl = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bit wants_write();
        return (f3[1:0] == 2'b01) || ((f3[1:0] != 2'b00) && (zimm != 5'd0));
    endfunction

    // One clock edge of the architectural rules, using the current inputs.
    function automatic st_t m_step(st_t s);
        st_t n;
        bit impl, ro;
        logic [63:0] old, src, v, mk;
        n = s; mk = msk(s);
        if (rst) begin
            n.mtvec = s.mtvr & ~64'h3;
            n.mscratch = 0; n.mepc = 0; n.mcause = 0; n.mtval = 0;
            n.cyc = 0; n.ins = 0; n.mie = 1'b0; n.mpie = 1'b0;
            return n;
        end
        n.cyc = s.cyc + 64'd1;
        if (inc) n.ins = s.ins + 64'd1;
        if (trap_valid) begin
            n.mepc = pc & mk & ~64'h3; n.mcause = cause & mk; n.mtval = tval & mk;
            n.mpie = s.mie; n.mie = 1'b0;
        end else if (mret_valid) begin
            n.mie = s.mpie; n.mpie = 1'b1;
        end else if (csr_valid) begin
            old = m_read(s, addr, impl, ro);
            src = f3[2] ? {59'd0, zimm} : (rs1 & mk);
            if (impl && !ro && wants_write()) begin
                case (f3[1:0])
                    2'b01:   v = src;
                    2'b10:   v = old | src;
                    default: v = old & ~src;
                endcase
                v = v & mk;
                case (addr)
                    12'h300: begin n.mie = v[3]; n.mpie = v[7]; end
                    12'h305: n.mtvec = (v & ~64'h3) | ((v[1:0] == 2'b01) ? 64'h1 : 64'h0);
                    12'h340: n.mscratch = v;
                    12'h341: n.mepc = v & ~64'h3;
                    12'h342: n.mcause = v;
                    12'h343: n.mtval = v;
                    12'hB00: n.cyc = (s.xl == 32) ? {s.cyc[63:32], v[31:0]} : v;
                    12'hB02: n.ins = (s.xl == 32) ? {s.ins[63:32], v[31:0]} : v;
                    12'hB80: n.cyc = {v[31:0], s.cyc[31:0]};
                    12'hB82: n.ins = {v[31:0], s.ins[31:0]};
                    default: ;
                endcase
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] m_vec(st_t s);
        logic [63:0] base, mk;
        bit msb;
        mk = msk(s);
        base = s.mtvec & ~64'h3;
        msb = (s.xl == 32) ? cause[31] : cause[63];
        if (s.mtvec[1:0] == 2'b01 && msb) return (base + ((cause & (mk >> 1)) << 2)) & mk;
        return base;
    endfunction

    // Compare all outputs mid-cycle, then advance DUT and model one edge.
    task automatic step_chk();
        bit i32, r32, i64, r64;
        logic [63:0] e32, e64;
        @(negedge clk);
        e32 = m_read(m32, addr, i32, r32);
        e64 = m_read(m64, addr, i64, r64);
        chk("rd32",   64'(rd32), e32);
        chk("ill32",  64'(ill32), 64'(csr_valid && (!i32 || (r32 && wants_write()))));
        chk("tvec32", 64'(tv32), m_vec(m32));
        chk("mepc32", 64'(mepc32), m32.mepc);
        chk("irq32",  64'(irq32), 64'(m32.mie));
        chk("rd64",   rd64, e64);
        chk("ill64",  64'(ill64), 64'(csr_valid && (!i64 || (r64 && wants_write()))));
        chk("tvec64", tv64, m_vec(m64));
        chk("mepc64", mepc64, m64.mepc);
        chk("irq64",  64'(irq64), 64'(m64.mie));
        @(posedge clk);
        m32 = m_step(m32);
        m64 = m_step(m64);
        #1;
    endtask

    task automatic clr();
        rst = 0; csr_valid = 0; f3 = 3'd0; addr = 12'd0; rs1 = 0; zimm = 5'd0;
        trap_valid = 0; cause = 0; pc = 0; tval = 0; mret_valid = 0; inc = 0;
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_valid = 0; addr = a;
        #1;
        chk(tag, 64'(rd32), 64'(exp));
    endtask

    task automatic csr_op(input logic [2:0] f, input logic [11:0] a, input logic [63:0] d,
                          input logic [4:0] z);
        clr(); csr_valid = 1; f3 = f; addr = a; rs1 = d; zimm = z;
    endtask

    initial begin
        m32 = '{xl: 32, hart: 64'd5, mtvr: 64'h200, default: '0};
        m64 = '{xl: 64, hart: 64'd9, mtvr: 64'h1_0000_0400, default: '0};
        clr();
        rst = 1;
        repeat (2) begin
            @(posedge clk);
            m32 = m_step(m32);
            m64 = m_step(m64);
        end
        #1;
        clr();
        chk("rst_irq", 64'(irq32), 64'd0);
        chk("rst_mepc", 64'(mepc32), 64'd0);
        chk("rst_tvec32", 64'(tv32), 64'h200);
        chk("rst_tvec64", tv64, 64'h1_0000_0400);
        peek("rst_mstatus", 12'h300, 32'h1800);
        peek("rst_mtvec", 12'h305, 32'h200);
        peek("rst_mcycle", 12'hB00, 32'd0);

        csr_op(3'd1, 12'h305, 64'h8000_0003, 5'd1);
        #1 chk("mtvec_old", 64'(rd32), 64'h200);
        step_chk();
        peek("mtvec_warl", 12'h305, 32'h8000_0000);

        csr_op(3'd6, 12'h300, 0, 5'd8);
        step_chk();
        chk("csrrsi_mie", 64'(irq32), 64'd1);

        csr_op(3'd1, 12'h305, 64'h101, 5'd1);
        step_chk();
        clr(); trap_valid = 1; cause = 64'h8000_0007; pc = 64'h1002; tval = 64'h33;
        #1 chk("vec_irq", 64'(tv32), 64'h11C);
        step_chk();
        clr();
        chk("trap_mie", 64'(irq32), 64'd0);
        chk("trap_mepc", 64'(mepc32), 64'h1000);
        peek("trap_mstatus", 12'h300, 32'h1880);

        clr(); mret_valid = 1;
        step_chk();
        peek("mret_mstatus", 12'h300, 32'h1888);

        csr_op(3'd1, 12'h340, 64'h55, 5'd1);
        trap_valid = 1; cause = 64'h2; pc = 64'h2000;
        step_chk();
        peek("trap_beats_wr", 12'h340, 32'h0);
        peek("trap_cause", 12'h342, 32'h2);

        csr_op(3'd2, 12'hF14, 64'h1234, 5'd0);
        #1 chk("hart_rd", 64'(rd32), 64'd5);
        chk("hart_ill", 64'(ill32), 64'd0);
        step_chk();
        csr_op(3'd1, 12'hF14, 64'h77, 5'd3);
        #1 chk("hart_rw_ill", 64'(ill32), 64'd1);
        step_chk();
        peek("hart_kept", 12'hF14, 32'd5);
        csr_op(3'd2, 12'h7C0, 64'h1, 5'd3);
        #1 chk("bad_addr_ill", 64'(ill32), 64'd1);
        chk("bad_addr_rd", 64'(rd32), 64'd0);
        step_chk();

        csr_op(3'd1, 12'hB00, 64'hFFFF_FFFF, 5'd1);
        step_chk();
        csr_op(3'd1, 12'hB80, 64'hFFFF_FFFF, 5'd1);
        #1 chk("mcycleh_ill64", 64'(ill64), 64'd1);
        step_chk();
        clr();
        step_chk();
        peek("mcycle_wrap", 12'hB00, 32'd0);
        peek("mcycleh_wrap", 12'hB80, 32'd0);

        csr_op(3'd1, 12'hB02, 0, 5'd1);
        step_chk();
        csr_op(3'd1, 12'hB82, 0, 5'd1);
        step_chk();
        for (int i = 0; i < 5; i++) begin
            clr(); inc = 1; step_chk();
            clr(); step_chk();
        end
        peek("minstret5", 12'hB02, 32'd5);

        clr(); trap_valid = 1; cause = 64'h8000_0003; pc = 64'h3004; tval = 64'h99;
        step_chk();
        clr(); rst = 1; mret_valid = 1;
        step_chk();
        clr();
        chk("mid_rst_irq", 64'(irq32), 64'd0);
        chk("mid_rst_tvec", 64'(tv32), 64'h200);
        peek("mid_rst_mstatus", 12'h300, 32'h1800);
        peek("mid_rst_mepc", 12'h341, 32'h0);
        peek("mid_rst_mcause", 12'h342, 32'h0);
        peek("mid_rst_mtval", 12'h343, 32'h0);
        peek("mid_rst_mtvec", 12'h305, 32'h200);
        peek("mid_rst_mcycle", 12'hB00, 32'h0);

        for (int k = 0; k < 1500; k++) begin
            rst        = ($urandom_range(0, 63) == 0);
            csr_valid  = 1'($urandom_range(0, 1));
            f3         = f3s[$urandom_range(0, 5)];
            addr       = ($urandom_range(0, 3) == 0) ? 12'($urandom) : adrs[$urandom_range(0, 11)];
            rs1        = {$urandom, $urandom};
            zimm       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            trap_valid = ($urandom_range(0, 9) == 0);
            cause      = {$urandom, $urandom};
            pc         = {$urandom, $urandom};
            tval       = {$urandom, $urandom};
            mret_valid = ($urandom_range(0, 9) == 0);
            inc        = 1'($urandom_range(0, 1));
            step_chk();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
